// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for a small CPU.
// Walks IDLE -> FETCH -> EXEC (-> MEM) -> FETCH ... -> DONE. It owns the
// program counter, a sticky memory-timeout flag and a saturating count of
// busy cycles. Strobes are decoded combinationally from state and opcode.
module cpu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  prog_len,
  input  logic [2:0]  opcode,
  input  logic        bne_taken,
  input  logic [9:0]  branch_target,
  input  logic        mem_ack,
  output logic [9:0]  pc,
  output logic        ir_load,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        done,
  output logic        err,
  output logic [15:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_STORE  = 3'b100;
  localparam logic [2:0] OP_BNE    = 3'b110;
  // Last wait-counter value: the 16th MEM cycle without an ack times out.
  localparam logic [3:0] WAIT_LAST = 4'd15;

  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_pc;
  logic [9:0]  w_pc_next;
  logic [9:0]  r_len;
  logic [9:0]  w_len_next;
  logic        r_err;
  logic        w_err_next;
  logic [3:0]  r_wait;
  logic [3:0]  w_wait_next;
  logic [15:0] r_cycle;
  logic [15:0] w_cycle_next;
  logic [9:0]  w_pc_inc;
  logic        w_pc_update;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_busy;

  // 10-bit modulo increment: 1023 wraps to 0.
  assign w_pc_inc   = r_pc + 10'd1;
  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);
  assign w_busy     = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_MEM);

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Program counter, latched length, error flag, wait counter and cycle count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= 10'd0;
      r_len   <= 10'd0;
      r_err   <= 1'b0;
      r_wait  <= 4'd0;
      r_cycle <= 16'd0;
    end else begin
      r_pc    <= w_pc_next;
      r_len   <= w_len_next;
      r_err   <= w_err_next;
      r_wait  <= w_wait_next;
      r_cycle <= w_cycle_next;
    end
  end

  // Next-state, register next values and strobe decode.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_len_next   = r_len;
    w_err_next   = r_err;
    w_wait_next  = r_wait;
    w_cycle_next = r_cycle;
    w_pc_update  = 1'b0;
    ir_load      = 1'b0;
    reg_we       = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_pc_next    = 10'd0;
          w_cycle_next = 16'd0;
          w_err_next   = 1'b0;
          w_len_next   = prog_len;
          w_state_next = (prog_len == 10'd0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        ir_load      = 1'b1;
        w_state_next = S_EXEC;
      end

      S_EXEC: begin
        case (opcode)
          OP_LOAD: begin
            mem_re       = 1'b1;
            w_wait_next  = 4'd0;
            w_state_next = S_MEM;
          end
          OP_STORE: begin
            mem_we       = 1'b1;
            w_wait_next  = 4'd0;
            w_state_next = S_MEM;
          end
          OP_BNE: begin
            w_pc_next   = bne_taken ? branch_target : w_pc_inc;
            w_pc_update = 1'b1;
          end
          default: begin
            reg_we      = 1'b1;
            w_pc_next   = w_pc_inc;
            w_pc_update = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        // Request is held for the whole MEM stay, including the ack cycle.
        mem_re = w_is_load;
        mem_we = w_is_store;
        if (mem_ack) begin
          reg_we      = w_is_load;
          w_pc_next   = w_pc_inc;
          w_pc_update = 1'b1;
        end else if (r_wait == WAIT_LAST) begin
          // Give up: flag the error and stop with pc left on the stuck access.
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_wait_next = r_wait + 4'd1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Completion is judged on the new (wrapped) pc for every pc update,
    // branches included.
    if (w_pc_update) begin
      w_state_next = (w_pc_next >= r_len) ? S_DONE : S_FETCH;
    end

    if (w_busy && (r_cycle != 16'hFFFF)) begin
      w_cycle_next = r_cycle + 16'd1;
    end
  end

  assign pc          = r_pc;
  assign err         = r_err;
  assign cycle_count = r_cycle;
  assign done        = (r_state == S_DONE);

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begins program execution when sampled high in IDLE or DONE.
REQ-004 SHALL have port prog_len, input, 10 bits: number of instructions; sampled only in IDLE/DONE when start=1.
REQ-005 SHALL have port opcode, input, 3 bits: instr[8:6] from the instruction register, stable from EXEC through MEM.
REQ-006 SHALL have port bne_taken, input, 1 bit: datapath compare result, valid in EXEC.
REQ-007 SHALL have port branch_target, input, 10 bits: absolute branch PC, valid in EXEC.
REQ-008 SHALL have port mem_ack, input, 1 bit: data-memory completion pulse.
REQ-009 SHALL have port pc, output, 10 bits: program counter (registered).
REQ-010 SHALL have port ir_load, output, 1 bit: instruction-register load strobe.
REQ-011 SHALL have port reg_we, output, 1 bit: register-file write strobe.
REQ-012 SHALL have port mem_re, output, 1 bit: data-memory read request.
REQ-013 SHALL have port mem_we, output, 1 bit: data-memory write request.
REQ-014 SHALL have port done, output, 1 bit: program finished.
REQ-015 SHALL have port err, output, 1 bit: memory timeout occurred (registered, sticky until next start).
REQ-016 SHALL have port cycle_count, output, 16 bits: execution cycles (registered).

Function
REQ-017 SHALL implement states IDLE, FETCH, EXEC, MEM, DONE.
REQ-018 Strobe outputs SHALL be combinational from the state and opcode; pc, err, and cycle_count SHALL be registered.
REQ-019 In IDLE or DONE with start=1: pc<=0, cycle_count<=0, err<=0, latch prog_len; next state SHALL be FETCH, or DONE if prog_len==0.
REQ-020 In FETCH: ir_load=1 for exactly one cycle; next state SHALL be EXEC.
REQ-021 In EXEC with opcode 000/001/010/101/111: reg_we=1 for one cycle, pc<=pc+1.
REQ-022 In EXEC with opcode 110 (BNE): reg_we=0; pc<=branch_target if bne_taken, else pc+1.
REQ-023 In EXEC with opcode 011 (load): mem_re=1; next state SHALL be MEM.
REQ-024 In EXEC with opcode 100 (store): mem_we=1; next state SHALL be MEM.
REQ-025 In MEM: mem_re/mem_we SHALL stay asserted until mem_ack=1.
REQ-026 In MEM, on the mem_ack cycle: reg_we=1 for a load (0 for a store), pc<=pc+1.
REQ-027 mem_ack SHALL be ignored outside MEM.
REQ-028 MEM timeout: a 4-bit wait counter clears on MEM entry; 16 consecutive MEM cycles without mem_ack SHALL set err=1, deassert requests, go to DONE, and leave pc unchanged.
REQ-029 Completion: after any pc update, next state SHALL be DONE if new pc >= latched prog_len (10-bit unsigned), else FETCH.
REQ-030 Completion SHALL use the same rule for a branch target beyond prog_len.
REQ-031 PC arithmetic is 10-bit modulo: pc+1 from 1023 SHALL wrap to 0; completion is evaluated on the wrapped value.
REQ-032 cycle_count SHALL increment in FETCH, EXEC, and MEM, and saturate at 16'hFFFF.
REQ-033 cycle_count SHALL hold in IDLE and DONE.
REQ-034 done SHALL be 1 exactly while in DONE; start in DONE restarts per REQ-019.
REQ-035 start SHALL be ignored in FETCH, EXEC, and MEM.

Reset
REQ-036 reset=1 SHALL force IDLE and pc=0, cycle_count=0, err=0, with all strobes and done at 0 on the next edge, from any state, including mid-MEM.
REQ-037 reset SHALL take priority over start and mem_ack in the same cycle.

Verification
REQ-038 prog_len=3, opcodes 000,001,010, start pulse -> pc 0,1,2,3; three reg_we pulses; done high after cycle 6; cycle_count=6.
REQ-039 prog_len=4, BNE at pc=1, bne_taken=1, target=3, opcode at 3 = 101 -> pc sequence 0,1,3,4; pc=2 never fetched; done asserted.
REQ-040 Load at pc=0, mem_ack after 3 wait cycles -> mem_re high 4 cycles; reg_we only on the ack cycle; pc=1 afterwards.
REQ-041 Store with mem_ack never asserted -> after 16 MEM cycles err=1, done=1, pc=0, mem_we low.
REQ-042 Reset asserted in MEM of a store -> next cycle state IDLE, mem_we=0, pc=0, done=0; later start restarts normally.
REQ-043 prog_len=0 with start -> done=1 one cycle later; cycle_count=0; no ir_load.
